// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
//  Module   : branch_predictor
//  Purpose  : Direct-mapped branch target buffer with 2-bit saturating
//             direction counters. Supplies a same-cycle next-PC prediction
//             to fetch and is trained from the resolved-branch stage. Also
//             keeps a saturating count of reported mispredictions.
//  Revision : 1.0  initial release
// ============================================================================
module branch_predictor #(
  parameter int XLEN     = 64,
  parameter int ENTRIES  = 16,
  parameter int TAG_BITS = 8,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  // fetch-side lookup
  input  logic [XLEN-1:0]   lookup_pc,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [XLEN-1:0]   pred_next_pc,
  // resolved-branch update
  input  logic              upd_valid,
  input  logic [XLEN-1:0]   upd_pc,
  input  logic              upd_taken,
  input  logic [XLEN-1:0]   upd_target,
  input  logic              upd_mispredict,
  // maintenance / statistics
  input  logic              bp_flush,
  output logic [CNT_W-1:0]  mispredict_count
);

  // Index sits directly above the ignored byte-offset bits, tag directly above
  // the index. Bits above the tag are not stored, so far-apart PCs may alias.
  localparam int IW     = $clog2(ENTRIES);
  localparam int IDX_LO = 2;
  localparam int IDX_HI = IW + 1;
  localparam int TAG_LO = IW + 2;
  localparam int TAG_HI = IW + 1 + TAG_BITS;

  localparam logic [1:0] CTR_MAX   = 2'b11;
  localparam logic [1:0] CTR_MIN   = 2'b00;
  localparam logic [1:0] CTR_ALLOC = 2'b10;  // weakly taken on allocation
  localparam logic [1:0] CTR_RESET = 2'b01;  // weakly not-taken after reset

  // --------------------------------------------------------------------------
  // Entry storage
  // --------------------------------------------------------------------------
  logic                valid_q  [ENTRIES];
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [XLEN-1:0]     target_q [ENTRIES];
  logic [1:0]          ctr_q    [ENTRIES];

  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_d;

  // --------------------------------------------------------------------------
  // Address decode for both ports
  // --------------------------------------------------------------------------
  logic [IW-1:0]       lk_idx;
  logic [TAG_BITS-1:0] lk_tag;
  logic [IW-1:0]       up_idx;
  logic [TAG_BITS-1:0] up_tag;

  assign lk_idx = lookup_pc[IDX_HI:IDX_LO];
  assign lk_tag = lookup_pc[TAG_HI:TAG_LO];
  assign up_idx = upd_pc[IDX_HI:IDX_LO];
  assign up_tag = upd_pc[TAG_HI:TAG_LO];

  // PC bits outside index/tag do not participate in prediction.
  logic unused_hi_bits;
  generate
    if (TAG_HI + 1 < XLEN) begin : g_unused_hi
      assign unused_hi_bits = ^{lookup_pc[XLEN-1:TAG_HI+1], upd_pc[XLEN-1:TAG_HI+1]};
    end else begin : g_no_unused_hi
      assign unused_hi_bits = 1'b0;
    end
  endgenerate

  logic unused_pc_bits;
  assign unused_pc_bits = ^{unused_hi_bits, lookup_pc[1:0], upd_pc[1:0]};

  // --------------------------------------------------------------------------
  // Lookup: purely combinational, reads the registered (pre-update) contents
  // --------------------------------------------------------------------------
  logic lk_hit;
  logic lk_taken;

  // Zero-latency prediction from the indexed entry; fall-through is PC+4.
  always_comb begin
    lk_hit       = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    lk_taken     = lk_hit && ctr_q[lk_idx][1];
    pred_hit     = lk_hit;
    pred_taken   = lk_taken;
    pred_next_pc = lk_taken ? target_q[lk_idx] : (lookup_pc + XLEN'(4));
  end

  // --------------------------------------------------------------------------
  // Update: compute the new contents of the single indexed entry
  // --------------------------------------------------------------------------
  logic                up_hit;
  logic                wr_en_d;
  logic                valid_d;
  logic [TAG_BITS-1:0] tag_d;
  logic [XLEN-1:0]     target_d;
  logic [1:0]          ctr_d;

  // Train the counter on a hit; allocate only on a taken miss.
  always_comb begin
    up_hit   = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    wr_en_d  = 1'b0;
    valid_d  = valid_q[up_idx];
    tag_d    = tag_q[up_idx];
    target_d = target_q[up_idx];
    ctr_d    = ctr_q[up_idx];

    // A flush discards any update presented in the same cycle.
    if (upd_valid && !bp_flush) begin
      if (up_hit) begin
        wr_en_d = 1'b1;
        if (upd_taken) begin
          ctr_d    = (ctr_q[up_idx] == CTR_MAX) ? CTR_MAX : (ctr_q[up_idx] + 2'd1);
          target_d = upd_target;
        end else begin
          ctr_d    = (ctr_q[up_idx] == CTR_MIN) ? CTR_MIN : (ctr_q[up_idx] - 2'd1);
        end
      end else if (upd_taken) begin
        wr_en_d  = 1'b1;
        valid_d  = 1'b1;
        tag_d    = up_tag;
        target_d = upd_target;
        ctr_d    = CTR_ALLOC;
      end
    end
  end

  // Saturating mispredict statistic; a flush does not suppress counting.
  always_comb begin
    cnt_d = cnt_q;
    if (upd_valid && upd_mispredict && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // State registers: reset beats flush, flush beats update
  // --------------------------------------------------------------------------

  // Entry array and statistic counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= CTR_RESET;
      end
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (bp_flush) begin
        for (int i = 0; i < ENTRIES; i++) begin
          valid_q[i] <= 1'b0;
        end
      end else if (wr_en_d) begin
        valid_q[up_idx]  <= valid_d;
        tag_q[up_idx]    <= tag_d;
        target_q[up_idx] <= target_d;
        ctr_q[up_idx]    <= ctr_d;
      end
    end
  end

  assign mispredict_count = cnt_q;

endmodule
`default_nettype wire
